fifo_serializer: RTL and testbench

- Downstream consumer of the 16-bit synchronous FIFO.
- Pops one word at a time using the FIFO's get/empty_bar handshake and transmits it as an asynchronous-style serial frame on a single line: start bit, WIDTH data bits LSB-first, one stop bit.
- Bit period is a fixed number of clk cycles.
- Sits between the FIFO and the board-level serial pin.

---
 rtl/fifo_ser_pkg.sv | 18 +
 rtl/ser_bit_timer.sv | 30 +++
 rtl/fifo_serializer.sv | 112 +++++++++++
 tb/tb_fifo_serializer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_ser_pkg.sv
// Shared types and line levels for the FIFO-fed serial transmitter.
// Holds the FSM state enum and the tx levels for idle, start and stop bits.
package fifo_ser_pkg;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        START,
        DATA,
        STOP
    } ser_state_e;

    localparam logic TX_IDLE   = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/ser_bit_timer.sv
// Bit-period timer: counts clk cycles within one serial bit.
// Ports: clk, reset (sync, active-high), run (count enable), tick (last cycle of a bit).
module ser_bit_timer #(
    parameter int CLKS_PER_BIT = 4,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = run && (cnt == LAST);

    // Counter is held at zero outside a frame so every bit starts aligned.
    always_ff @(posedge clk) begin
        if (reset || !run) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fifo_serializer.sv
// Pops words from a synchronous FIFO and sends each as a start/data(LSB first)/stop frame.
// Ports: clk, reset, enable, empty_bar, data_in (FIFO side); get, tx, busy, frame_done.
module fifo_serializer
    import fifo_ser_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             empty_bar,
    input  logic [WIDTH-1:0] data_in,
    output logic             get,
    output logic             tx,
    output logic             busy,
    output logic             frame_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    ser_state_e       state;
    logic [WIDTH-1:0] shreg;
    logic [IDX_W-1:0] idx;
    logic             run;
    logic             tick;

    assign run = (state == START) || (state == DATA) || (state == STOP);

    // Decoded from registered state and counter only; no input path.
    assign frame_done = (state == STOP) && tick;

    ser_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .CNT_W       (CNT_W)
    ) u_timer (
        .clk  (clk),
        .reset(reset),
        .run  (run),
        .tick (tick)
    );

    // Outputs are loaded on the edge that enters the state they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            tx    <= TX_IDLE;
            get   <= 1'b0;
            busy  <= 1'b0;
            shreg <= '0;
            idx   <= '0;
        end else begin
            get <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable && empty_bar) begin
                        state <= POP;
                        get   <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                POP: begin
                    state <= LOAD;
                end
                LOAD: begin
                    shreg <= data_in;
                    state <= START;
                    tx    <= START_BIT;
                end
                START: begin
                    if (tick) begin
                        state <= DATA;
                        idx   <= '0;
                        tx    <= shreg[0];
                    end
                end
                DATA: begin
                    if (tick) begin
                        shreg <= shreg >> 1;
                        if (idx == LAST_IDX) begin
                            state <= STOP;
                            idx   <= '0;
                            tx    <= STOP_BIT;
                        end else begin
                            idx <= idx + IDX_W'(1);
                            tx  <= shreg[1];
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (enable && empty_bar) begin
                            state <= POP;
                            get   <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= TX_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_serializer.sv
// Self-checking bench for fifo_serializer with a behavioural FIFO model.
// Covers idle after reset, single frames, back-to-back, enable drop, reset mid-frame, CLKS_PER_BIT=2.
module tb_fifo_serializer;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        empty_bar;
    logic [15:0] data_in = '0;
    logic        get;
    logic        tx;
    logic        busy;
    logic        frame_done;

    logic        en2;
    logic        eb2;
    logic [15:0] din2;
    logic        get2;
    logic        tx2;
    logic        busy2;
    logic        fd2;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int get_cnt = 0;
    int get_cyc [0:63];
    int fd_cnt = 0;
    int bad_pop = 0;

    logic [15:0] mem [0:63];
    int wp = 0;
    int rp = 0;

    always #5 clk = ~clk;

    fifo_serializer dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .empty_bar (empty_bar),
        .data_in   (data_in),
        .get       (get),
        .tx        (tx),
        .busy      (busy),
        .frame_done(frame_done)
    );

    fifo_serializer #(.CLKS_PER_BIT(2)) dut2 (
        .clk       (clk),
        .reset     (reset),
        .enable    (en2),
        .empty_bar (eb2),
        .data_in   (din2),
        .get       (get2),
        .tx        (tx2),
        .busy      (busy2),
        .frame_done(fd2)
    );

    assign empty_bar = (wp != rp);

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: word appears on data_in the cycle after get.
    always @(posedge clk) begin
        if (get) begin
            if (wp == rp) bad_pop <= bad_pop + 1;
            data_in <= mem[rp % 64];
            rp <= rp + 1;
        end
    end

    always @(negedge clk) begin
        if (get) begin
            if (get_cnt < 64) get_cyc[get_cnt] = cyc;
            get_cnt++;
        end
        if (frame_done) fd_cnt++;
    end

    typedef struct {
        string       name;
        logic [15:0] word;
        logic [15:0] exp_word;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] w);
        mem[wp % 64] = w;
        wp = wp + 1;
    endtask

    function automatic logic txs(input bit sel);
        return sel ? tx2 : tx;
    endfunction

    function automatic logic fds(input bit sel);
        return sel ? fd2 : frame_done;
    endfunction

    function automatic logic exp_tx(input logic [15:0] w, input int cpb, input int c);
        if (c < cpb) return 1'b0;
        if (c < 17 * cpb) return w[(c - cpb) / cpb];
        return 1'b1;
    endfunction

    // Call at a negedge; waits for the start bit, then samples the whole frame.
    task automatic capture(input bit sel, input int cpb, input logic [15:0] exp,
                           input string nm, input int drop_at, output int fall_cyc);
        int n;
        int bad;
        int fdc;
        int fdat;
        int len;
        logic [15:0] got;
        n = 0;
        fall_cyc = -1;
        while (txs(sel) !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            chk({nm, " start timeout"}, 1, 0);
            return;
        end
        fall_cyc = cyc;
        len = 18 * cpb;
        bad = 0;
        fdc = 0;
        fdat = -1;
        got = '0;
        for (int c = 0; c < len; c++) begin
            if (c > 0) @(negedge clk);
            if (c == drop_at) enable = 1'b0;
            if (txs(sel) !== exp_tx(exp, cpb, c)) bad++;
            if (c >= cpb && c < 17 * cpb && ((c - cpb) % cpb) == cpb / 2)
                got[(c - cpb) / cpb] = txs(sel);
            if (fds(sel)) begin
                fdc++;
                fdat = c;
            end
        end
        chk({nm, " tx cycles wrong"}, bad, 0);
        chk({nm, " word"}, int'(got), int'(exp));
        chk({nm, " frame_done count"}, fdc, 1);
        chk({nm, " frame_done cycle"}, fdat, len - 1);
    endtask

    initial begin
        int bad;
        int g0;
        int f0;
        int fc1;
        int fc2;
        int e_cyc;
        int n;

        vecs[0] = '{"a5c3", 16'hA5C3, 16'hA5C3};
        vecs[1] = '{"zero", 16'h0000, 16'h0000};
        vecs[2] = '{"ones", 16'hFFFF, 16'hFFFF};
        vecs[3] = '{"1234", 16'h1234, 16'h1234};

        reset = 1'b1;
        enable = 1'b1;
        en2 = 1'b1;
        eb2 = 1'b0;
        din2 = '0;
        repeat (3) @(negedge clk);
        chk("reset tx", int'(tx), 1);
        chk("reset get", int'(get), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset frame_done", int'(frame_done), 0);
        reset = 1'b0;

        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx !== 1'b1 || get !== 1'b0 || busy !== 1'b0) bad++;
        end
        chk("idle 20 cycles", bad, 0);

        foreach (vecs[i]) begin
            g0 = get_cnt;
            push(vecs[i].word);
            capture(1'b0, 4, vecs[i].exp_word, vecs[i].name, -1, fc1);
            repeat (3) @(negedge clk);
            chk({vecs[i].name, " get pulses"}, get_cnt - g0, 1);
            chk({vecs[i].name, " busy after"}, int'(busy), 0);
        end

        g0 = get_cnt;
        push(16'h0001);
        push(16'hFFFF);
        capture(1'b0, 4, 16'h0001, "b2b f1", -1, fc1);
        capture(1'b0, 4, 16'hFFFF, "b2b f2", -1, fc2);
        repeat (3) @(negedge clk);
        chk("b2b get pulses", get_cnt - g0, 2);
        if (get_cnt - g0 == 2)
            chk("b2b get spacing", get_cyc[g0 + 1] - get_cyc[g0], 74);
        chk("b2b fall spacing", fc2 - fc1, 74);

        g0 = get_cnt;
        push(16'h00FF);
        push(16'hF00F);
        capture(1'b0, 4, 16'h00FF, "drop f1", 30, fc1);
        repeat (20) @(negedge clk);
        chk("drop no second get", get_cnt - g0, 1);
        chk("drop idle busy", int'(busy), 0);
        chk("drop idle tx", int'(tx), 1);
        enable = 1'b1;
        e_cyc = cyc;
        capture(1'b0, 4, 16'hF00F, "drop f2", -1, fc2);
        chk("drop restart latency", fc2 - e_cyc, 3);

        repeat (3) @(negedge clk);
        f0 = fd_cnt;
        push(16'h3C3C);
        push(16'h5A5A);
        n = 0;
        while (tx !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rst fall seen", int'(n < 100), 1);
        repeat (25) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst tx", int'(tx), 1);
        chk("rst busy", int'(busy), 0);
        reset = 1'b0;
        chk("rst no frame_done", fd_cnt - f0, 0);
        capture(1'b0, 4, 16'h5A5A, "rst next", -1, fc1);

        repeat (3) @(negedge clk);
        eb2 = 1'b1;
        n = 0;
        while (get2 !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("cpb2 get seen", int'(n < 20), 1);
        din2 = 16'h8000;
        eb2 = 1'b0;
        capture(1'b1, 2, 16'h8000, "cpb2", -1, fc1);
        repeat (5) @(negedge clk);
        chk("cpb2 busy after", int'(busy2), 0);

        chk("no pop while empty", bad_pop, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
